// File: rtl/multicycle_alu.sv
// Registered ALU with iterative multiply and shifts behind a start/busy/done handshake.
// Single-cycle ops finish on the accept edge; mul takes WIDTH cycles, shifts take min(amount, WIDTH).
module multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] single_res;
  logic             single_carry;
  logic             shift_req;
  logic             multi;
  logic [CW-1:0]    start_cnt;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] iter_res;

  // add and sub share one adder; sub is DATA1 + ~DATA2 + 1 so carry means no-borrow
  assign is_sub = (select == OP_SUB);
  assign b_in   = is_sub ? ~data2 : data2;
  assign sum    = {1'b0, data1} + {1'b0, b_in} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    single_res   = data1;
    single_carry = 1'b0;
    case (select)
      OP_FWD: single_res = data2;
      OP_ADD, OP_SUB: begin
        single_res   = sum[WIDTH-1:0];
        single_carry = sum[WIDTH];
      end
      OP_AND: single_res = data1 & data2;
      OP_OR:  single_res = data1 | data2;
      default: ;
    endcase
  end

  assign shift_req = (select == OP_SLL) || (select == OP_SRA);
  assign multi     = (select == OP_MUL) || (shift_req && (data2 != '0));

  always_comb begin
    start_cnt = WIDTH_C;
    if (select != OP_MUL && data2 < WIDTH_V)
      start_cnt = data2[CW-1:0];
  end

  // One adder plus a small mux per iteration: mul accumulates, shifts move one bit
  assign acc_nxt  = acc_q + (b_q[0] ? a_q : '0);
  assign a_nxt    = (op_q == OP_SRA) ? {a_q[WIDTH-1], a_q[WIDTH-1:1]} : {a_q[WIDTH-2:0], 1'b0};
  assign iter_res = (op_q == OP_MUL) ? acc_nxt : a_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= select;
            a_q   <= data1;
            b_q   <= data2;
            acc_q <= '0;
            if (multi) begin
              state <= EXEC;
              cnt_q <= start_cnt;
            end else begin
              result <= single_res;
              zero   <= (single_res == '0);
              carry  <= single_carry;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          a_q   <= a_nxt;
          b_q   <= b_q >> 1;
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result <= iter_res;
            zero   <= (iter_res == '0);
            carry  <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == EXEC);

endmodule
